// File: rtl/apb_regfile_completer.sv
// APB completer with a small register file, programmable wait states and error response.
// Registers are exported in parallel together with one-cycle write strobes.
module apb_regfile_completer #(
    parameter int          NREGS       = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [31:0]           PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [NREGS*32-1:0]   reg_out,
    output logic [NREGS-1:0]      wr_pulse
);
    localparam int IW = $clog2(NREGS);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [31:0]         prdata_q, prdata_d;
    logic [NREGS-1:0]    wr_pulse_q, wr_pulse_d;
    logic [31:0]         regs_q [NREGS];
    logic [31:0]         regs_d [NREGS];

    logic [31:0]         dec_off;
    logic [IW-1:0]       dec_idx;
    logic                dec_err;
    logic                in_range;
    logic                commit;

    // Decode with 64-bit bounds so a window at the top of the map cannot wrap.
    always_comb begin
        dec_off  = PADDR - BASE_ADDR;
        dec_idx  = IW'(dec_off >> 2);
        in_range = (PADDR >= BASE_ADDR) &&
                   ({32'b0, PADDR} < ({32'b0, BASE_ADDR} + 64'(4 * NREGS)));
        dec_err  = !in_range || (PADDR[1:0] != 2'b00) || (PWRITE && dec_idx == '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                    idx_d   = dec_idx;
                    wr_d    = PWRITE;
                    err_d   = dec_err;
                    wdata_d = PWDATA;
                    rdata_d = (dec_idx == '0) ? ID_VALUE : regs_q[dec_idx];
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    commit  = PENABLE && wr_q && !err_q;
                end
            end
            default: state_d = IDLE;
        endcase

        regs_d = regs_q;
        if (commit) regs_d[idx_q] = wdata_q;
        wr_pulse_d = commit ? (NREGS'(1) << idx_q) : '0;

        // Response outputs are registered from the next state, never from the bus.
        pready_d  = (state_d == ACCESS) && (cnt_d == '0);
        pslverr_d = pready_d && err_d;
        prdata_d  = (pready_d && !err_d && !wr_d) ? rdata_d : '0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign PRDATA   = prdata_q;
    assign wr_pulse = wr_pulse_q;

    for (genvar i = 0; i < NREGS; i++) begin : g_out
        if (i == 0) begin : g_id
            assign reg_out[31:0] = ID_VALUE;
        end else begin : g_rw
            assign reg_out[32*i +: 32] = regs_q[i];
        end
    end
endmodule

// File: doc/apb_regfile_completer.md
# apb_regfile_completer

APB completer (slave) exposing a small memory-mapped register file with a programmable number of wait states and error signalling. It is the responder side of the APB master/bridge. It sits on one PSELx line of the bridge and drives PRDATA, PREADY and PSLVERR to zero whenever it is not completing a transfer, so the bridge's wired-OR response bus stays valid. Register contents are also exported in parallel, with per-register write strobes, to downstream logic.

## Interface
- NREGS, 8, number of 32-bit registers (2..64); register 0 is the read-only ID register.
- WAIT_STATES, 0, number of PREADY-low access cycles inserted before completion (0..15).
- ID_VALUE, 32'hA5B0_0001, constant returned by register 0.
- BASE_ADDR, 32'h0000_0000, byte address of register 0; must be aligned to the window size.
- PCLK  in  1  APB clock, rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; zero except in the completion cycle of an OK read.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error flag; valid only when PREADY=1.
- reg_out  out  NREGS*32  flattened register contents; register i occupies bits [32*i+31:32*i].
- wr_pulse  out  NREGS  one-cycle strobe, bit i set in the cycle after register i is written.

## Operation
- State machine: IDLE, ACCESS.
- IDLE to ACCESS: on a clock edge with PSEL=1 and PENABLE=0 (setup phase), capture the following:
  - PADDR, PWRITE and PWDATA;
  - the decoded index, (PADDR-BASE_ADDR)>>2;
  - the error flag;
  - the read data;
  - wait counter ← WAIT_STATES.
- Error flag is set when any of these holds:
  - PADDR < BASE_ADDR, or PADDR ≥ BASE_ADDR+4*NREGS;
  - PADDR[1:0] ≠ 0;
  - a write to register 0.
- ACCESS with counter ≠ 0: PREADY=0, counter decrements each edge.
- ACCESS with counter = 0: PREADY=1, and PSLVERR = captured error flag. PRDATA = captured read data for an OK read, else 0.
  - On the following edge, if PSEL=1 and PENABLE=1: an OK write updates the register, then the state returns to IDLE.
- Errored transfers change no register and pulse no strobe.
- PSEL=0 while in ACCESS is an abort: return to IDLE with no write and no strobe, and PREADY/PSLVERR/PRDATA return to 0.
- A setup phase seen while already in ACCESS is ignored until the current transfer completes or aborts.
- Read data is sampled at the setup edge. A write completing before the next setup is therefore visible to that read (back-to-back write then read).
- Register 0 always reads ID_VALUE. Registers 1..NREGS-1 are read/write.

## Timing
- Reset (asynchronous, PRESETn low):
  - state=IDLE, counter=0;
  - PREADY=0, PSLVERR=0, PRDATA=0;
  - registers 1..NREGS-1 = 0, wr_pulse=0;
  - takes effect immediately, including mid-transfer; the aborted transfer never commits.
- PREADY, PSLVERR and PRDATA are decoded from registered state only, with no combinational path from APB inputs.
- Latency with setup at edge T0 (PSEL=1, PENABLE=0):
  - PREADY=1 during cycle T0+1+WAIT_STATES;
  - the transfer ends at the edge closing that cycle;
  - WAIT_STATES=0 gives the standard 2-cycle zero-wait transfer.
- Write commit: register updated at the completion edge; reg_out shows the new value and wr_pulse[i]=1 for exactly the next cycle.
- PREADY is high for exactly one cycle per transfer and is never high in IDLE.
- Minimum transfer spacing: a new setup may occur in the cycle immediately after completion.

## Test plan
- Reset, then read offset 0x0 (WAIT_STATES=0) → PREADY=1 in the 2nd cycle, PRDATA=32'hA5B0_0001, PSLVERR=0; PRDATA=0 in all other cycles.
- Write 32'hDEAD_BEEF to 0x8, then read 0x8 back-to-back:
  - reg_out[95:64]=32'hDEAD_BEEF;
  - wr_pulse=8'b0000_0100 for one cycle;
  - the read returns 32'hDEAD_BEEF.
- WAIT_STATES=3, write 0x4 → PREADY low for 3 access cycles, high on the 4th, register updated only at that edge.
- Error cases, each giving PSLVERR=1 with PREADY, no register change and wr_pulse=0:
  - write to 0x0;
  - read at 0x20 with NREGS=8;
  - write to misaligned 0x6.
- Abort: WAIT_STATES=2, write 0xC, drop PSEL during the 1st access cycle → PREADY never asserts, register 3 unchanged, next transfer works normally.
- Write 32'h1234_5678 to 0x4; assert PRESETn low mid-access of a write of 32'hFFFF_FFFF to 0x4 → all outputs 0 immediately, register 1 = 0 after reset, no wr_pulse.
